// File: rtl/data_gen_cfg.sv
// Stimulus source for the spam-filter dataflow path.
// One ap_start pulse produces a burst of configuration words on Output_1,
// then a burst of training-data words on Output_2, then a single
// ap_done/ap_ready pulse (ap_ctrl_hs handshake).
module data_gen_cfg #(
  parameter int          CFG_WORDS  = 16,
  parameter int          DATA_WORDS = 1024,
  parameter logic [31:0] CFG_TAG    = 32'hBF7C_0000
) (
  input  logic         ap_clk,
  input  logic         ap_rst_n,
  input  logic         ap_start,
  output logic         ap_done,
  output logic         ap_idle,
  output logic         ap_ready,
  output logic [63:0]  Output_1_TDATA,
  output logic         Output_1_TVALID,
  input  logic         Output_1_TREADY,
  output logic [511:0] Output_2_TDATA,
  output logic         Output_2_TVALID,
  input  logic         Output_2_TREADY
);

  localparam logic [31:0] CFG_LAST  = 32'(CFG_WORDS - 1);
  localparam logic [31:0] DATA_LAST = 32'(DATA_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CFG  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] cfg_idx;
  logic [31:0] data_idx;
  logic [31:0] lane_base;

  // First lane value of the current data word: data_idx * 16 (mod 2^32).
  assign lane_base = {data_idx[27:0], 4'b0000};

  // State register; reset drops any word in flight and returns to IDLE.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Word counters: cleared in IDLE so every run restarts at index 0,
  // advanced only on a VALID&READY handshake.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cfg_idx  <= '0;
      data_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          cfg_idx  <= '0;
          data_idx <= '0;
        end
        CFG: begin
          if (Output_1_TREADY) begin
            cfg_idx <= cfg_idx + 32'd1;
          end
        end
        DATA: begin
          if (Output_2_TREADY) begin
            data_idx <= data_idx + 32'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state and outputs. VALID and TDATA depend only on registered
  // state and counters, so they stay stable across READY stalls and never
  // follow READY combinationally.
  always_comb begin
    state_nxt       = state;
    ap_done         = 1'b0;
    ap_ready        = 1'b0;
    ap_idle         = 1'b0;
    Output_1_TVALID = 1'b0;
    Output_1_TDATA  = '0;
    Output_2_TVALID = 1'b0;
    Output_2_TDATA  = '0;
    case (state)
      IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          state_nxt = CFG;
        end
      end
      CFG: begin
        Output_1_TVALID = 1'b1;
        Output_1_TDATA  = {CFG_TAG, cfg_idx};
        if (Output_1_TREADY && (cfg_idx == CFG_LAST)) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        Output_2_TVALID = 1'b1;
        for (int k = 0; k < 16; k++) begin
          Output_2_TDATA[32*k +: 32] = lane_base + 32'(k);
        end
        if (Output_2_TREADY && (data_idx == DATA_LAST)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        ap_done   = 1'b1;
        ap_ready  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_data_gen_cfg.sv
// Directed + randomized-backpressure bench for data_gen_cfg.
// Instance a uses a small run (4 config / 3 data words); instance b uses
// the default sizes.
module tb_data_gen_cfg;

  localparam int SMALL_CFG  = 4;
  localparam int SMALL_DATA = 3;
  localparam int DEF_CFG    = 16;
  localparam int DEF_DATA   = 1024;

  logic         clk = 1'b0;
  logic         rst_a, start_a, done_a, idle_a, ready_a;
  logic [63:0]  d1_a;
  logic         v1_a, r1_a;
  logic [511:0] d2_a;
  logic         v2_a, r2_a;
  logic         rst_b, start_b, done_b, idle_b, ready_b;
  logic [63:0]  d1_b;
  logic         v1_b, r1_b;
  logic [511:0] d2_b;
  logic         v2_b, r2_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_gen_cfg #(.CFG_WORDS(SMALL_CFG), .DATA_WORDS(SMALL_DATA)) dut_a (
    .ap_clk(clk), .ap_rst_n(rst_a), .ap_start(start_a),
    .ap_done(done_a), .ap_idle(idle_a), .ap_ready(ready_a),
    .Output_1_TDATA(d1_a), .Output_1_TVALID(v1_a), .Output_1_TREADY(r1_a),
    .Output_2_TDATA(d2_a), .Output_2_TVALID(v2_a), .Output_2_TREADY(r2_a)
  );

  data_gen_cfg dut_b (
    .ap_clk(clk), .ap_rst_n(rst_b), .ap_start(start_b),
    .ap_done(done_b), .ap_idle(idle_b), .ap_ready(ready_b),
    .Output_1_TDATA(d1_b), .Output_1_TVALID(v1_b), .Output_1_TREADY(r1_b),
    .Output_2_TDATA(d2_b), .Output_2_TVALID(v2_b), .Output_2_TREADY(r2_b)
  );

  // Reference: n-th config word is the fixed tag over the index.
  function automatic logic [63:0] cfg_word(input int unsigned n);
    return {32'hBF7C_0000, n};
  endfunction

  // Reference: lane k of data word j holds j*16+k, wrapping at 2^32.
  function automatic logic [511:0] data_word(input int unsigned j);
    logic [511:0] w;
    int unsigned  v;
    w = '0;
    for (int k = 0; k < 16; k++) begin
      v = j * 16 + k;
      w[32*k +: 32] = v;
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet_a(input string tag, input bit with_data);
    chk({tag, "_v1"}, v1_a, 1'b0);
    chk({tag, "_v2"}, v2_a, 1'b0);
    chk({tag, "_idle"}, idle_a, 1'b1);
    chk({tag, "_done"}, done_a, 1'b0);
    chk({tag, "_ready"}, ready_a, 1'b0);
    if (with_data) begin
      chk({tag, "_d1"}, d1_a, 64'd0);
      chk({tag, "_d2"}, d2_a, 512'd0);
    end
  endtask

  // Exact cycle-by-cycle timing with both sinks always ready.
  task automatic timed_run();
    bit v1e, v2e;
    @(posedge clk); #1 start_a = 1'b1; r1_a = 1'b1; r2_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      v1e = (c >= 1) && (c <= SMALL_CFG);
      v2e = (c > SMALL_CFG) && (c <= SMALL_CFG + SMALL_DATA);
      chk($sformatf("t_v1_c%0d", c), v1_a, v1e);
      chk($sformatf("t_v2_c%0d", c), v2_a, v2e);
      if (v1e) chk($sformatf("t_d1_c%0d", c), d1_a, cfg_word(c - 1));
      if (v2e) chk($sformatf("t_d2_c%0d", c), d2_a, data_word(c - SMALL_CFG - 1));
      if (c == 6) begin
        chk("t_lane0_j1", d2_a[31:0], 32'd16);
        chk("t_lane15_j1", d2_a[511:480], 32'd31);
      end
      chk($sformatf("t_done_c%0d", c), done_a, c == 8);
      chk($sformatf("t_ready_c%0d", c), ready_a, c == 8);
      chk($sformatf("t_idle_c%0d", c), idle_a, c == 9);
    end
  endtask

  // One run on instance a with optional random READY and optional ap_start
  // pokes while data words are being emitted.
  task automatic run_bp(input bit rnd, input bit poke, input string tag);
    int ncfg = 0, ndata = 0, ndone = 0, cyc = 0, after = 0;
    logic v1p = 1'b0, v2p = 1'b0, r1p = 1'b0, r2p = 1'b0;
    logic [63:0]  d1p = '0;
    logic [511:0] d2p = '0;
    @(posedge clk); #1 start_a = 1'b1;
    r1_a = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    r2_a = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    while (after < 4 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (v1p && !r1p) begin
        chk({tag, "_hold_v1"}, v1_a, 1'b1);
        chk({tag, "_hold_d1"}, d1_a, d1p);
      end
      if (v2p && !r2p) begin
        chk({tag, "_hold_v2"}, v2_a, 1'b1);
        chk({tag, "_hold_d2"}, d2_a, d2p);
      end
      chk({tag, "_excl"}, v1_a & v2_a, 1'b0);
      if (v1_a && r1_a) begin
        chk($sformatf("%s_cfg%0d", tag, ncfg), d1_a, cfg_word(ncfg));
        ncfg++;
      end
      if (v2_a && r2_a) begin
        chk($sformatf("%s_data%0d", tag, ndata), d2_a, data_word(ndata));
        ndata++;
      end
      if (done_a) begin
        ndone++;
        chk({tag, "_ready_w_done"}, ready_a, 1'b1);
      end else if (ndone > 0) begin
        chk({tag, "_idle_after"}, idle_a, 1'b1);
        chk({tag, "_v1_after"}, v1_a, 1'b0);
      end
      if (ndone > 0) after++;
      v1p = v1_a; v2p = v2_a; r1p = r1_a; r2p = r2_a; d1p = d1_a; d2p = d2_a;
      @(posedge clk); #1;
      if (rnd) begin
        r1_a = 1'($urandom_range(0, 1));
        r2_a = 1'($urandom_range(0, 1));
      end
      start_a = poke && v2p;
    end
    start_a = 1'b0;
    chk({tag, "_no_timeout"}, cyc < 400, 1'b1);
    chk({tag, "_ncfg"}, ncfg, SMALL_CFG);
    chk({tag, "_ndata"}, ndata, SMALL_DATA);
    chk({tag, "_ndone"}, ndone, 1);
  endtask

  initial begin
    int n, cyc, ncfg, ndata, ndone, after;
    rst_a = 1'b0; start_a = 1'b0; r1_a = 1'b0; r2_a = 1'b0;
    rst_b = 1'b0; start_b = 1'b0; r1_b = 1'b1; r2_b = 1'b1;

    // Reset values, then quiet after release.
    #12;
    check_quiet_a("rst", 1'b1);
    @(posedge clk); #1 rst_a = 1'b1; rst_b = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_quiet_a("post_rst", 1'b1);

    // Exact timing with READY=1.
    timed_run();

    // Random backpressure on both streams.
    for (int r = 0; r < 4; r++) run_bp(1'b1, 1'b0, $sformatf("bp%0d", r));

    // ap_start pokes during DATA must be ignored.
    run_bp(1'b1, 1'b1, "poke");
    run_bp(1'b0, 1'b1, "poke_full");

    // Reset after two config handshakes, then a fresh run from index 0.
    @(posedge clk); #1 start_a = 1'b1; r1_a = 1'b1; r2_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    n = 0; cyc = 0;
    while (n < 2 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (v1_a && r1_a) n++;
    end
    chk("mid_two_hs", n, 2);
    @(posedge clk); #1 rst_a = 1'b0;
    #1;
    check_quiet_a("mid_rst", 1'b1);
    @(posedge clk); #1 rst_a = 1'b1;
    @(negedge clk);
    check_quiet_a("mid_rel", 1'b0);
    run_bp(1'b1, 1'b0, "rerun");

    // Default sizes, both sinks always ready.
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    ncfg = 0; ndata = 0; ndone = 0; cyc = 0; after = 0;
    while (after < 3 && cyc < 1200) begin
      @(negedge clk);
      cyc++;
      if (v1_b) begin
        chk($sformatf("def_cfg%0d", ncfg), d1_b, cfg_word(ncfg));
        ncfg++;
      end
      if (v2_b) begin
        chk($sformatf("def_data%0d", ndata), d2_b, data_word(ndata));
        ndata++;
      end
      if (done_b) begin
        ndone++;
        chk("def_ready_w_done", ready_b, 1'b1);
      end
      if (ndone > 0) after++;
    end
    chk("def_no_timeout", cyc < 1200, 1'b1);
    chk("def_ncfg", ncfg, DEF_CFG);
    chk("def_ndata", ndata, DEF_DATA);
    chk("def_ndone", ndone, 1);
    chk("def_idle_end", idle_b, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
